// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-serial valid/ready link feeding the boot loader.
interface boot_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   modport master (output rx_data, rx_valid, input rx_ready);
   modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed, checksummed image into instruction ROM
// and holds the CPU in reset until the image is complete and verified.
module boot_loader #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 16,
   parameter int MAX_WORDS = 32768
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   boot_loader_if.slave      rx,
   input  logic              i_reload,
   output logic [ADDR_W-1:0] o_rom_addr,
   output logic [DATA_W-1:0] o_rom_wdata,
   output logic              o_rom_we,
   output logic              o_cpu_reset,
   output logic              o_load_done,
   output logic              o_error,
   output logic [15:0]       o_word_count
);
   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN, S_ERR
   } state_t;
   state_t            r_state, w_next;
   logic              w_xfer, w_last;
   logic [15:0]       w_len, r_len, r_word_count;
   logic [7:0]        r_hi, r_sum;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [DATA_W-1:0] r_rom_wdata;
   logic              r_rom_we;
   assign w_xfer = rx.rx_valid & rx.rx_ready;
   assign w_len  = {r_len[15:8], rx.rx_data};
   assign w_last = (r_word_count + 16'd1) == r_len;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_LEN_HI;
      else          r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LEN_HI:  if (w_xfer) w_next = S_LEN_LO;
         S_LEN_LO:  if (w_xfer) w_next = (w_len == 16'd0) ? S_CSUM :
                                        ({1'b0, w_len} > 17'(MAX_WORDS)) ? S_ERR : S_DATA_HI;
         S_DATA_HI: if (w_xfer) w_next = S_DATA_LO;
         S_DATA_LO: if (w_xfer) w_next = w_last ? S_CSUM : S_DATA_HI;
         S_CSUM:    if (w_xfer) w_next = (rx.rx_data == r_sum) ? S_RUN : S_ERR;
         S_RUN:     if (i_reload) w_next = S_LEN_HI;
         default:   w_next = r_state;
      endcase
   end
   always_comb begin
      rx.rx_ready = !(r_state == S_RUN || r_state == S_ERR);
      o_cpu_reset = r_state != S_RUN;
      o_load_done = r_state == S_RUN;
      o_error     = r_state == S_ERR;
   end
   // word_count doubles as the 0-based ROM index of the word being assembled
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_len        <= '0;
         r_hi         <= '0;
         r_sum        <= '0;
         r_word_count <= '0;
         r_rom_addr   <= '0;
         r_rom_wdata  <= '0;
         r_rom_we     <= 1'b0;
      end else begin
         r_rom_we <= 1'b0;
         if (w_xfer)
            case (r_state)
               S_LEN_HI: r_len <= {rx.rx_data, 8'd0};
               S_LEN_LO: r_len <= w_len;
               S_DATA_HI: begin
                  r_hi  <= rx.rx_data;
                  r_sum <= r_sum + rx.rx_data;
               end
               S_DATA_LO: begin
                  r_rom_we     <= 1'b1;
                  r_rom_wdata  <= DATA_W'({r_hi, rx.rx_data});
                  r_rom_addr   <= r_word_count[ADDR_W-1:0];
                  r_word_count <= r_word_count + 16'd1;
                  r_sum        <= r_sum + rx.rx_data;
               end
               default: ;
            endcase
         if (r_state == S_RUN && i_reload) begin
            r_word_count <= '0;
            r_sum        <= '0;
         end
      end
   assign o_rom_addr   = r_rom_addr;
   assign o_rom_wdata  = r_rom_wdata;
   assign o_rom_we     = r_rom_we;
   assign o_word_count = r_word_count;
endmodule
